// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: 8x oversampling on the system clock feeding a FWFT byte FIFO.
// Defining UART_RX_PARITY_EN adds an even-parity bit to the frame and enables parity_err.
module uart_rx_buffered #(
   parameter int TICK_DIV = 4,
   parameter int DEPTH    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   parity_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd5,
`endif
      S_STOP   = 3'd3,
      S_WAIT   = 3'd4
   } state_t;

`ifdef UART_RX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction
`endif

   state_t        state_q, state_d;
   logic          sync1_q, rxs_q;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    os_q, os_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          s3_q, s3_d, s4_q, s4_d;
   logic          frame_err_q, frame_err_d;
   logic          tick_s, mid_s, end_s, maj_s, push_s;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
   logic          parity_err_q, parity_err_d;
`endif

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d, full_q, full_d;
   logic          overrun_q, overrun_d;
   logic          pop_s, wr_ok_s;

   assign tick_s = (state_q != S_IDLE) && (div_q == DIV_MAX);
   assign mid_s  = tick_s && (os_q == 3'd5);
   assign end_s  = tick_s && (os_q == 3'd7);
   // Majority of the samples taken at os 3, 4 and the live sample at os 5.
   assign maj_s  = (s3_q & s4_q) | (s3_q & rxs_q) | (s4_q & rxs_q);

   // Two-flop synchronizer for the asynchronous serial input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= rx;
         rxs_q   <= sync1_q;
      end
   end

   // Receiver next-state: oversample timing, bit sampling and frame sequencing.
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      os_d        = os_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      s3_d        = s3_q;
      s4_d        = s4_q;
      push_s      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      if (state_q == S_IDLE) begin
         div_d = {DW{1'b0}};
         os_d  = 3'd0;
      end else if (tick_s) begin
         div_d = {DW{1'b0}};
         os_d  = os_q + 3'd1;
      end else begin
         div_d = div_q + DW'(1);
      end
      if (tick_s && (os_q == 3'd3)) s3_d = rxs_q;
      else                           s3_d = s3_q;
      if (tick_s && (os_q == 3'd4)) s4_d = rxs_q;
      else                           s4_d = s4_q;

      case (state_q)
         S_IDLE: begin
            if (!rxs_q) state_d = S_START;
            else        state_d = S_IDLE;
         end
         S_START: begin
            if (mid_s && maj_s) begin
               state_d = S_IDLE;
            end else if (end_s) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (mid_s) begin
               shreg_d = {maj_s, shreg_q[7:1]};
            end else if (end_s) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid_s)      par_bad_d = (maj_s != even_parity(shreg_q));
            else if (end_s) state_d   = S_STOP;
            else            state_d   = S_PARITY;
         end
`endif
         S_STOP: begin
            // A good stop bit releases the line at mid-bit so frames can run back to back.
            if (mid_s) begin
               if (maj_s) begin
                  push_s  = 1'b1;
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = par_bad_q;
`endif
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         S_WAIT: begin
            if (rxs_q) state_d = S_IDLE;
            else       state_d = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         div_q       <= {DW{1'b0}};
         os_q        <= 3'd0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 8'h00;
         s3_q        <= 1'b1;
         s4_q        <= 1'b1;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         os_q        <= os_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         s3_q        <= s3_d;
         s4_q        <= s4_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign pop_s   = rd_en && !empty_q;
   assign wr_ok_s = push_s && (!full_q || pop_s);

   // FIFO next-state; a push into a full FIFO succeeds only when a pop frees a slot.
   always_comb begin
      mem_d = mem_q;
      if (wr_ok_s) mem_d[wr_ptr_q] = shreg_q;
      else         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      wr_ptr_d  = wr_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d  = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d   = count_q + CW'(wr_ok_s) - CW'(pop_s);
      full_d    = (count_d == CNT_FULL);
      empty_d   = (count_d == {CW{1'b0}});
      overrun_d = push_s && full_q && !pop_s;
   end

   // FIFO storage, pointers and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         overrun_q <= overrun_d;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign empty     = empty_q;
   assign full      = full_q;
   assign count     = count_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
